// File: rtl/irq_queue_ctrl.sv
// irq_queue_ctrl: interrupt front-end. It detects rising edges on the request
// lines and records them in masked pending bits. One pending line per cycle is
// granted, by round-robin or fixed priority. Each grant pushes vector
// (line + 1) into a show-ahead FIFO.
//
// Handshake: vec_valid/vec present the FIFO head. The head is consumed on a
// clk edge where eirq and vec_valid are both high; eirq while empty is ignored.
module irq_queue_ctrl #(
   parameter int NIRQ  = 7,
   parameter int VW    = $clog2(NIRQ + 1),
   parameter int DEPTH = 16,
   parameter int MODE  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NIRQ-1:0]        irq_in,
   input  logic [NIRQ-1:0]        mask,
   input  logic                   eirq,
   input  logic                   clr_ovf,
   output logic                   vec_valid,
   output logic [VW-1:0]          vec,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
   localparam int SW = PW + 1;   // holds rr_ptr + offset before the modulo fold

   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] pend_q, pend_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [VW-1:0]   mem_q [DEPTH];

   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] gnt_oh;
   logic            pop;
   logic            space;
   logic            gnt_found;
   logic [PW-1:0]   gnt_idx;
   logic [PW-1:0]   cand;
   logic [SW-1:0]   cand_sum;
   logic [VW-1:0]   push_vec;

   assign rise     = irq_in & ~irq_q & ~mask;
   assign pop      = eirq & vec_valid;
   // A pop in the same edge frees a slot, so a full FIFO still accepts a grant
   assign space    = (count_q < CW'(DEPTH)) | pop;
   assign push_vec = VW'(gnt_idx) + VW'(1);

   // Arbitration: choose at most one pending line when the FIFO can take it
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      cand_sum  = '0;
      if (space) begin
         for (int k = 0; k < NIRQ; k++) begin
            if (MODE == 1) begin
               cand_sum = SW'(k);
            end else begin
               cand_sum = {1'b0, rr_ptr_q} + SW'(k);
               if (cand_sum >= SW'(NIRQ)) cand_sum = cand_sum - SW'(NIRQ);
            end
            cand = cand_sum[PW-1:0];
            if (!gnt_found && pend_q[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
      gnt_oh = gnt_found ? (NIRQ'(1) << gnt_idx) : '0;
   end

   // Next-state: pending bits, round-robin pointer, FIFO pointers, sticky ovf
   always_comb begin
      // a rise on the line being granted re-arms its pend bit
      pend_d   = (pend_q & ~gnt_oh) | rise;
      rr_ptr_d = rr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (gnt_found) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (gnt_idx == PW'(NIRQ - 1)) rr_ptr_d = '0;
         else                          rr_ptr_d = gnt_idx + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({gnt_found, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // a rise landing on a still-pending, ungranted line is lost; set beats clear
      if (|(rise & pend_q & ~gnt_oh)) ovf_d = 1'b1;
      else if (clr_ovf)               ovf_d = 1'b0;
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q    <= '0;
         pend_q   <= '0;
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         irq_q    <= irq_in;
         pend_q   <= pend_d;
         rr_ptr_q <= rr_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; no reset needed since count gates what is visible
   always_ff @(posedge clk) begin
      if (gnt_found) mem_q[wr_ptr_q] <= push_vec;
   end

   assign vec_valid = (count_q != '0);
   assign vec       = vec_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_queue_ctrl.sv
// Bench for irq_queue_ctrl: a round-robin and a fixed-priority instance
// (NIRQ=7, DEPTH=4) share stimulus. A queue-based reference model is compared
// against both instances every cycle, and directed scenarios pin literal values.
module tb_irq_queue_ctrl;
   localparam int NIRQ  = 7;
   localparam int DEPTH = 4;
   localparam int VW    = 3;
   localparam int CW    = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NIRQ-1:0] irq_in  = '0;
   logic [NIRQ-1:0] mask    = '0;
   logic            eirq    = 1'b0;
   logic            clr_ovf = 1'b0;

   logic            a_vec_valid, b_vec_valid;
   logic [VW-1:0]   a_vec, b_vec;
   logic [CW-1:0]   a_count, b_count;
   logic            a_ovf, b_ovf;

   irq_queue_ctrl #(.NIRQ(NIRQ), .DEPTH(DEPTH), .MODE(0)) dut_a (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .eirq(eirq),
      .clr_ovf(clr_ovf), .vec_valid(a_vec_valid), .vec(a_vec),
      .count(a_count), .ovf(a_ovf));

   irq_queue_ctrl #(.NIRQ(NIRQ), .DEPTH(DEPTH), .MODE(1)) dut_b (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .eirq(eirq),
      .clr_ovf(clr_ovf), .vec_valid(b_vec_valid), .vec(b_vec),
      .count(b_count), .ovf(b_ovf));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, want, $time);
      end
   endtask

   // Reference model: index 0 = round-robin instance, 1 = fixed priority
   logic [VW-1:0]   exp_q0[$];
   logic [VW-1:0]   exp_q1[$];
   logic [NIRQ-1:0] m_pend [2] = '{'0, '0};
   int              m_rr   [2] = '{0, 0};
   bit              m_ovf  [2] = '{1'b0, 1'b0};
   logic [NIRQ-1:0] m_irq_prev = '0;

   always @(posedge clk or posedge rst) begin : model
      int sz, g, c;
      bit pp, sp;
      logic [NIRQ-1:0] rs, gm;
      if (rst) begin
         m_irq_prev = '0;
         for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_rr[m]   = 0;
            m_ovf[m]  = 1'b0;
         end
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         rs = irq_in & ~m_irq_prev & ~mask;
         for (int m = 0; m < 2; m++) begin
            sz = (m == 0) ? exp_q0.size() : exp_q1.size();
            pp = eirq && (sz > 0);
            sp = (sz < DEPTH) || pp;
            g  = -1;
            if (sp) begin
               for (int k = 0; k < NIRQ; k++) begin
                  c = (m == 1) ? k : (m_rr[m] + k) % NIRQ;
                  if (g < 0 && m_pend[m][c]) g = c;
               end
            end
            gm = (g >= 0) ? NIRQ'(1 << g) : '0;
            if ((rs & m_pend[m] & ~gm) != '0) m_ovf[m] = 1'b1;
            else if (clr_ovf)                 m_ovf[m] = 1'b0;
            m_pend[m] = (m_pend[m] & ~gm) | rs;
            if (pp) begin
               if (m == 0) void'(exp_q0.pop_front());
               else        void'(exp_q1.pop_front());
            end
            if (g >= 0) begin
               if (m == 0) exp_q0.push_back(VW'(g + 1));
               else        exp_q1.push_back(VW'(g + 1));
               m_rr[m] = (g + 1) % NIRQ;
            end
         end
         m_irq_prev = irq_in;
      end
   end

   // Compare both instances against the model on every falling edge
   always @(negedge clk) begin : compare
      chk("a.vec_valid", 32'(a_vec_valid), 32'(exp_q0.size() > 0));
      chk("a.vec", 32'(a_vec), (exp_q0.size() > 0) ? 32'(exp_q0[0]) : 32'd0);
      chk("a.count", 32'(a_count), 32'(exp_q0.size()));
      chk("a.ovf", 32'(a_ovf), 32'(m_ovf[0]));
      chk("b.vec_valid", 32'(b_vec_valid), 32'(exp_q1.size() > 0));
      chk("b.vec", 32'(b_vec), (exp_q1.size() > 0) ? 32'(exp_q1[0]) : 32'd0);
      chk("b.count", 32'(b_count), 32'(exp_q1.size()));
      chk("b.ovf", 32'(b_ovf), 32'(m_ovf[1]));
   end

   // ---------------- driver tasks ----------------
   int got_a[$];
   int got_b[$];

   task automatic pulse(input logic [NIRQ-1:0] lines);
      irq_in = lines;
      @(negedge clk);
      irq_in = '0;
      @(negedge clk);
   endtask

   // Pop until both instances are empty, recording each popped head
   task automatic drain();
      got_a.delete();
      got_b.delete();
      for (int i = 0; i < 40; i++) begin
         if (!a_vec_valid && !b_vec_valid) break;
         if (a_vec_valid) got_a.push_back(int'(a_vec));
         if (b_vec_valid) got_b.push_back(int'(b_vec));
         eirq = 1'b1;
         @(negedge clk);
      end
      eirq = 1'b0;
      chk("drain_empty", 32'(a_vec_valid | b_vec_valid), 32'd0);
   endtask

   int t2_a[3] = '{7, 1, 4};
   int t2_b[3] = '{1, 4, 7};

   // ---------------- directed + random stimulus ----------------
   initial begin : stim
      logic [7:0] seen;
      int twos;

      repeat (2) @(negedge clk);
      chk("rst.vec_valid", 32'(a_vec_valid), 32'd0);
      chk("rst.vec", 32'(a_vec), 32'd0);
      chk("rst.count", 32'(a_count), 32'd0);
      chk("rst.ovf", 32'(a_ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single event: line 2 -> vector 3, two clocks latency
      irq_in = 7'b0000100;
      @(negedge clk);
      irq_in = '0;
      chk("t1.early", 32'(a_vec_valid), 32'd0);
      @(negedge clk);
      chk("t1.valid", 32'(a_vec_valid), 32'd1);
      chk("t1.vec", 32'(a_vec), 32'd3);
      chk("t1.count", 32'(a_count), 32'd1);
      chk("t1.b.vec", 32'(b_vec), 32'd3);
      eirq = 1'b1;
      @(negedge clk);
      eirq = 1'b0;
      chk("t1.pop.valid", 32'(a_vec_valid), 32'd0);
      chk("t1.pop.vec", 32'(a_vec), 32'd0);
      chk("t1.pop.count", 32'(a_count), 32'd0);

      // move the round-robin pointer to 4 via a grant of line 3
      pulse(7'b0001000);
      repeat (2) @(negedge clk);
      drain();

      // simultaneous rises on lines 0, 3, 6
      pulse(7'b1001001);
      repeat (3) @(negedge clk);
      drain();
      chk("t2.a.n", 32'(got_a.size()), 32'd3);
      chk("t2.b.n", 32'(got_b.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("t2.a.order", 32'(i < got_a.size() ? got_a[i] : 0), 32'(t2_a[i]));
         chk("t2.b.order", 32'(i < got_b.size() ? got_b[i] : 0), 32'(t2_b[i]));
      end

      // fill and backpressure: 7 events into a 4-entry FIFO
      pulse(7'b1111111);
      repeat (8) @(negedge clk);
      chk("t3.a.count", 32'(a_count), 32'd4);
      chk("t3.b.count", 32'(b_count), 32'd4);
      chk("t3.a.ovf", 32'(a_ovf), 32'd0);
      drain();
      chk("t3.a.n", 32'(got_a.size()), 32'd7);
      chk("t3.b.n", 32'(got_b.size()), 32'd7);
      seen = '0;
      foreach (got_a[i]) seen[got_a[i][2:0]] = 1'b1;
      chk("t3.a.distinct", 32'(seen), 32'hFE);
      chk("t3.a.count0", 32'(a_count), 32'd0);

      // coalescing while full
      pulse(7'b0111100);
      repeat (6) @(negedge clk);
      chk("t4.full", 32'(a_count), 32'd4);
      pulse(7'b0000010);
      chk("t4.ovf_first", 32'(a_ovf), 32'd0);
      pulse(7'b0000010);
      chk("t4.a.ovf", 32'(a_ovf), 32'd1);
      chk("t4.b.ovf", 32'(b_ovf), 32'd1);
      drain();
      chk("t4.n", 32'(got_a.size()), 32'd5);
      twos = 0;
      foreach (got_a[i]) if (got_a[i] == 2) twos++;
      chk("t4.one_vec2", 32'(twos), 32'd1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("t4.clr", 32'(a_ovf), 32'd0);

      // mask: masked pulse, unmask while held high, then a fresh edge
      mask = 7'b0100000;
      pulse(7'b0100000);
      repeat (2) @(negedge clk);
      chk("t5.masked", 32'(a_count), 32'd0);
      irq_in = 7'b0100000;
      repeat (2) @(negedge clk);
      mask = '0;
      repeat (3) @(negedge clk);
      chk("t5.held", 32'(a_count), 32'd0);
      irq_in = '0;
      @(negedge clk);
      irq_in = 7'b0100000;
      @(negedge clk);
      irq_in = '0;
      @(negedge clk);
      chk("t5.vec", 32'(a_vec), 32'd6);
      chk("t5.count", 32'(a_count), 32'd1);
      drain();

      // asynchronous reset with vectors queued
      pulse(7'b0000111);
      repeat (5) @(negedge clk);
      chk("t6.queued", 32'(a_count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("t6.valid", 32'(a_vec_valid), 32'd0);
      chk("t6.count", 32'(a_count), 32'd0);
      chk("t6.vec", 32'(a_vec), 32'd0);
      chk("t6.ovf", 32'(a_ovf), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      eirq = 1'b1;
      repeat (3) @(negedge clk);
      eirq = 1'b0;
      chk("t6.stale", 32'(a_vec_valid | b_vec_valid), 32'd0);

      // randomized traffic with varying drain rate and one mid-cycle reset
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst     = 1'b0;
         irq_in  = NIRQ'($urandom);
         mask    = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom) : '0;
         eirq    = ($urandom_range(0, 7) < ((i / 250) % 8));
         clr_ovf = ($urandom_range(0, 15) == 0);
         if (i == 1500) begin
            #2 rst = 1'b1;
         end
      end
      @(negedge clk);
      irq_in = '0;
      eirq = 1'b0;
      clr_ovf = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_queue_ctrl.md
# irq_queue_ctrl

Parametrised interrupt front-end that replaces the fixed 7-line collector and the fixed 16-entry pending queue with one block. It detects rising edges on NIRQ request lines, applies a per-line mask, and arbitrates pending lines by round-robin or fixed priority. Granted vectors are pushed into a DEPTH-entry FIFO, which the core drains one vector per eirq acknowledge. It sits between the peripheral IRQ lines and the core's irq vector inputs.

## Interface
- NIRQ, 7: number of request lines (1..15); line i reports vector i+1.
- VW, $clog2(NIRQ+1): vector width, derived; vector 0 means "none".
- DEPTH, 16: FIFO entries; must be a power of two, 2..64.
- MODE, 0: arbitration mode; 0 = round-robin, 1 = fixed priority (line 0 highest).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- irq_in  in  NIRQ  request lines, synchronous to clk, level; edges are events.
- mask  in  NIRQ  1 = line disabled; edges on masked lines are discarded.
- eirq  in  1  core acknowledge/pop; pops the head when vec_valid=1.
- clr_ovf  in  1  clears the ovf sticky flag.
- vec_valid  out  1  FIFO non-empty.
- vec  out  VW  head vector (show-ahead); 0 when vec_valid=0.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky; an event was lost.

## Operation
- Edge detect: irq_q <= irq_in each clk. rise = irq_in & ~irq_q & ~mask.
- Pending register pend[NIRQ]: a bit sets on rise and clears when its line is granted. If rise and grant hit the same line in the same cycle, the bit stays set.
- Coalescing: a rise on a line whose pend bit is already set, and that line is not granted this cycle, is lost. This sets ovf.
- Grant: at most one line per cycle. A grant needs pend != 0 and space, where space = (count < DEPTH) | (eirq & vec_valid).
  - MODE 1: the lowest set index wins.
  - MODE 0: search starts at rr_ptr. After a grant of line g, rr_ptr <= (g+1) mod NIRQ.
- The granted line pushes vector g+1 into the FIFO.
- FIFO: circular, with wr_ptr, rd_ptr and count.
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged. This is legal when full and when count=1.
  - Pointers wrap modulo DEPTH.
- Pop happens on eirq & vec_valid. eirq while empty is ignored.
- vec is combinational from mem[rd_ptr], gated to 0 when empty.
- ovf behaviour:
  - Set by a coalesced rise.
  - Not set when the FIFO is full, because backpressure holds events in pend.
  - clr_ovf clears ovf. If a set and clr_ovf occur in the same cycle, the set wins.
- mask changes take effect the same cycle and affect only new rises. Already-pending bits still get granted.

## Timing
- Reset values:
  - irq_q, pend, rr_ptr, wr_ptr, rd_ptr, count, ovf = 0.
  - Outputs vec_valid=0, vec=0, count=0, ovf=0.
  - FIFO memory contents are don't-care.
- irq_in is high before posedge k with irq_q low: pend sets at k, grant and push happen at k+1, and vec_valid=1 and vec are valid during the cycle after k+1. Best-case latency is 2 clocks.
- Throughput: one push and one pop per clock.
- The cycle eirq is seen at posedge p, the next head appears after p. Back-to-back eirq drains one vector per clock.
- Reset asserted mid-operation clears all state immediately. Queued vectors are lost and ovf is not set.
- Full FIFO with no pop: pend bits hold and grants stall. On the first pop, a grant resumes in that same edge.

## Test plan
- Single event (MODE 0, NIRQ=7): pulse irq_in[2] one cycle → vec_valid rises 2 clocks later with vec=3 and count=1. Then eirq for one cycle → vec_valid=0, vec=0, count=0.
- Simultaneous rises on lines 0, 3, 6 in the same cycle:
  - MODE 1: pops yield 1, 4, 7.
  - MODE 0 starting from rr_ptr=4: pops yield 7, 1, 4.
- Fill and backpressure (DEPTH=4, NIRQ=7): fire all 7 lines with no eirq → count saturates at 4 and pend holds 3 bits, with ovf=0. Drain with continuous eirq → 7 distinct vectors arrive, count returns to 0, and there are no duplicates.
- Coalescing: rise on line 1, then a second rise on line 1 while the FIFO is full and pend[1]=1 → ovf=1 and only one vector 2 is delivered. clr_ovf → ovf=0.
- Mask: mask[5]=1 with a pulse on irq_in[5] → nothing is queued. mask[5]=0 while the line is held high → nothing is queued (no new edge). The next rise queues vector 6.
- Reset mid-queue: 3 vectors queued, then assert rst asynchronously mid-cycle → vec_valid, count, vec and ovf go to 0 immediately. After release, no stale vectors are popped.
